// File: rtl/mux_16x1_scanner.sv
// Sweeps the select of an upstream 16:1 registered mux through all channels,
// dwells LATENCY+1 cycles per channel, and assembles the samples into a word.
module mux_16x1_scanner #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mux_q,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] word
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Last dwell count equals LATENCY because the counter starts at zero.
    localparam logic [2:0] DWELL_LAST = 3'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] word_q, word_d;
    logic        done_q, done_d;
    logic        dwell_end;

    assign dwell_end = (cnt_q == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 4'd0;
            cnt_q   <= 3'd0;
            cap_q   <= 16'h0000;
            word_q  <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: if (dwell_end && (sel_q == 4'd15)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        cap_d  = cap_q;
        word_d = word_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = 4'd0;
                if (start) begin
                    cnt_d = 3'd0;
                    cap_d = 16'h0000;
                end
            end
            SCAN: begin
                if (dwell_end) begin
                    cnt_d        = 3'd0;
                    cap_d[sel_q] = mux_q;
                    if (sel_q == 4'd15) begin
                        // Bit 15 comes straight from mux_q: the capture register is not yet updated.
                        word_d = {mux_q, cap_q[14:0]};
                        done_d = 1'b1;
                        sel_d  = 4'd0;
                    end else begin
                        sel_d = sel_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                sel_d = 4'd0;
            end
        endcase
    end

    assign sel  = sel_q;
    assign busy = (state_q == SCAN);
    assign done = done_q;
    assign word = word_q;

endmodule

// File: tb/tb_mux_16x1_scanner.sv
// Bench for mux_16x1_scanner: one instance behind a two-stage mux model
// (LATENCY=2) and one behind a single-register mux model (LATENCY=1).
module tb_mux_16x1_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start2 = 1'b0, start1 = 1'b0;
    logic [15:0] data2 = 16'h0000, data1 = 16'h0000;
    logic        m2_s1, mux_q2, mux_q1;
    logic [3:0]  sel2, sel1;
    logic        busy2, busy1, done2, done1;
    logic [15:0] word2, word1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        m2_s1  <= data2[sel2];
        mux_q2 <= m2_s1;
        mux_q1 <= data1[sel1];
    end

    mux_16x1_scanner #(.LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mux_q(mux_q2),
        .sel(sel2), .busy(busy2), .done(done2), .word(word2)
    );

    mux_16x1_scanner #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mux_q(mux_q1),
        .sel(sel1), .busy(busy1), .done(done1), .word(word1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int lat, input logic [15:0] v);
        if (lat == 2) data2 = v; else data1 = v;
    endtask

    task automatic set_start(input int lat, input logic v);
        if (lat == 2) start2 = v; else start1 = v;
    endtask

    // Called and returns at a negedge. Expected bit k is the mux data seen by the
    // first mux register, i.e. the data in place just before edge S + DWELL*k + 1.
    task automatic run_scan(input int lat, input logic [15:0] d, input int chg_edge,
                            input logic [15:0] d_new, input bit rnd,
                            input bit extra_starts, input bit hold,
                            output logic [15:0] exp);
        int          dw;
        int          last;
        int          dones;
        int          k;
        logic [15:0] cur;
        logic [3:0]  s_obs;
        dw    = lat + 1;
        last  = 16 * dw;
        dones = 0;
        exp   = 16'h0000;
        set_data(lat, d);
        set_start(lat, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) set_start(lat, 1'b0);
        chk("busy_after_start", (lat == 2) ? busy2 : busy1, 1);
        chk("sel_after_start", (lat == 2) ? sel2 : sel1, 0);
        for (int e = 1; e <= last; e++) begin
            if (rnd) set_data(lat, 16'($urandom));
            if (e == chg_edge + 1) set_data(lat, d_new);
            if (extra_starts) set_start(lat, (e == 10) || (e == last) || hold);
            k = (e - 1) / dw;
            if ((e - 1) % dw == 0) begin
                cur    = (lat == 2) ? data2 : data1;
                exp[k] = cur[k];
                s_obs  = (lat == 2) ? sel2 : sel1;
                chk("sel_step", s_obs, k);
            end
            @(posedge clk);
            @(negedge clk);
            if (e < last && ((lat == 2) ? done2 : done1)) dones++;
        end
        chk("no_early_done", dones, 0);
        chk("done_pulse", (lat == 2) ? done2 : done1, 1);
        chk("busy_fall", (lat == 2) ? busy2 : busy1, 0);
        chk("sel_return", (lat == 2) ? sel2 : sel1, 0);
        chk("word_model", (lat == 2) ? word2 : word1, exp);
        if (extra_starts && !hold) begin
            set_start(lat, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("start_at_done_ignored", (lat == 2) ? busy2 : busy1, 0);
            chk("done_one_cycle", (lat == 2) ? done2 : done1, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp;
        int          dones;

        // Reset held two cycles with start asserted.
        reset  = 1'b1;
        start2 = 1'b1;
        start1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", sel2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_word", word2, 16'h0000);
        chk("rst_busy_l1", busy1, 0);
        chk("rst_word_l1", word1, 16'h0000);
        reset  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy2, 0);

        // Single scan with stray starts at S+10 and S+48.
        run_scan(2, 16'hA5C3, -1, 16'h0000, 1'b0, 1'b1, 1'b0, exp);
        chk("word_a5c3", word2, 16'hA5C3);

        // Start held high: back-to-back scans, period 49.
        run_scan(2, 16'h3C5A, -1, 16'h0000, 1'b0, 1'b0, 1'b1, exp);
        run_scan(2, 16'h0F0F, -1, 16'h0000, 1'b0, 1'b0, 1'b0, exp);
        chk("word_back_to_back", word2, 16'h0F0F);

        // Data changes just after channel 8's dwell begins.
        run_scan(2, 16'h0000, 24, 16'hFFFF, 1'b0, 1'b0, 1'b0, exp);
        chk("word_mid_change", word2, 16'hFF00);

        // Randomised data, changing every cycle.
        for (int i = 0; i < 3; i++) begin
            run_scan(2, 16'($urandom), -1, 16'h0000, 1'b1, 1'b0, 1'b0, exp);
        end

        // Reset mid-scan at S+20.
        run_scan(2, 16'h1234, -1, 16'h0000, 1'b0, 1'b0, 1'b0, exp);
        chk("word_1234", word2, 16'h1234);
        data2  = 16'hFFFF;
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy2, 0);
        chk("abort_sel", sel2, 0);
        chk("abort_word", word2, 16'h0000);
        chk("abort_done", done2, 0);
        dones = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (done2) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_word_hold", word2, 16'h0000);

        // LATENCY=1 instance: 2-cycle dwell, done after S+32.
        run_scan(1, 16'h8001, -1, 16'h0000, 1'b0, 1'b0, 1'b0, exp);
        chk("word_8001_l1", word1, 16'h8001);
        run_scan(1, 16'($urandom), -1, 16'h0000, 1'b1, 1'b0, 1'b0, exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_16x1_scanner.md
# mux_16x1_scanner

Sequencer and capture stage that sits directly downstream of the 16:1 registered multiplexer (Mux_16x1). On a start request it sweeps `sel` through channels 0..15 and holds each select long enough to cover the mux's pipeline latency. It samples the mux output once per channel and assembles the 16 samples into a parallel word. Typical uses are reading back a 16-bit data bus through the single-bit mux path, or periodic polling of 16 status lines.

## Interface
- `LATENCY`, 2, clock edges from a `sel` change to the matching mux output being registered; legal range 1..7. Mux_16x1 requires 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request; sampled only while `busy`=0.
- `mux_q`  in  1  registered output of the upstream 16:1 mux.
- `sel`  out  4  channel select driven to the mux; registered.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse marking scan completion; `word` is updated on the same edge.
- `word`  out  16  last completed scan result; bit k is channel k.

## Operation
- Reset (synchronous, active-high): `sel`=0, `busy`=0, `done`=0, `word`=16'h0000. The internal capture register, dwell counter and channel index are all cleared, and the FSM enters IDLE.
- FSM states are IDLE and SCAN.
- IDLE:
  - `sel` is held at 0.
  - `start`=1 on an edge moves the FSM to SCAN: `busy`<=1, `sel`<=0, dwell counter<=0, capture register cleared.
- SCAN:
  - Dwell per channel is DWELL = LATENCY+1 edges. `sel` stays constant for the whole dwell, so both mux stages see a consistent select.
  - On the last edge of a dwell, `mux_q` is sampled into capture bit `sel`. On that same edge `sel` increments and the dwell counter returns to 0.
  - On the dwell-end edge of channel 15: `word`<=capture with bit 15 equal to the current `mux_q`, `done`<=1, `busy`<=0, `sel`<=0, and the FSM returns to IDLE.
- `done` is high for exactly one cycle and is otherwise 0.
- `start` is ignored while `busy`=1 (no queuing). Holding `start` at 1 gives back-to-back scans separated by one IDLE cycle.
- `word` changes only on a `done` edge. It holds the previous result for the entire duration of a scan.
- Bit k reflects the upstream mux data during channel k's dwell window. Data that changes mid-scan is not re-sampled.
- Reset asserted mid-scan aborts the scan: no `done` is produced, and `word` returns to 0.
- The `sel` width is 4 bits and the channel index does not wrap within a scan. Termination is detected at index 15, not at overflow.

## Timing
- `start` is accepted on edge S. `busy`=1 and `sel`=0 are visible after S.
- Channel k is sampled on edge S + DWELL·(k+1), with DWELL = LATENCY+1.
- `sel`=k is visible from edge S + DWELL·k until edge S + DWELL·(k+1).
- With LATENCY=2: DWELL=3, and channel 15 is sampled on S+48.
- `done` and the new `word` are visible after S+48. `busy` is 0 after S+48.
- The next `start` can be accepted at S+49 at the earliest. The scan period with `start` held high is 49 cycles.
- Latency rule for LATENCY=2:
  - `sel` changes on E0.
  - The first mux stage captures on E1.
  - The second stage captures on E2 with `sel` still stable.
  - `mux_q` is valid between E2 and E3 and is sampled on E3.
- A `start` presented on the completion edge S+48 is ignored, because `busy` is still 1 before that edge.

## Test plan
- Reset: hold `reset` for 2 cycles with `start`=1 → `sel`=0, `busy`=0, `done`=0, `word`=16'h0000; no scan starts while reset is high.
- Single scan through the real Mux_16x1 with data=16'hA5C3 and `start` pulsed on edge S → `sel` steps 0..15 every 3 cycles, `done` pulses once after S+48, `word`=16'hA5C3, `busy` falls on the same edge.
- Busy/start interaction: pulse `start` again at S+10 and at S+48 → both are ignored, and exactly one `done` is produced. Then hold `start` high → the next scan begins at S+49 and `done` pulses again after S+97.
- Data change mid-scan: data=16'h0000, set data to 16'hFFFF just after edge S+24 (channel 8's dwell begins at S+24) → `word`=16'hFF00.
- Reset mid-scan at edge S+20 with data=16'hFFFF after a prior result of 16'h1234 → `busy`=0, `sel`=0, `word`=16'h0000 after the edge, and no `done` is produced.
- LATENCY=1 with a single-register behavioural mux model and data=16'h8001 → dwell is 2 cycles, `done` pulses after S+32, `word`=16'h8001.
